// File: rtl/encoder_scheduler_pkg.sv
// encoder_sched_pkg
// Shared widths, limits and the FSM state type for encoder_scheduler.
//   MSG_W   : message width fed to the (12,7) encoder
//   CW_W    : codeword width
//   CNT_W   : width of the serial bit counter
//   CW_LAST : index of the last codeword bit sent on the serial port
package encoder_sched_pkg;

    localparam int MSG_W   = 7;
    localparam int CW_W    = 12;
    localparam int CNT_W   = 4;
    localparam int CW_LAST = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

endpackage

// File: rtl/encoder_scheduler_encoder.sv
// encoder
// Combinational (12,7) block encoder: systematic message bits in c[6:0],
// parity bits in c[11:7]. Bits 9 and 10 carry the same parity equation.
// Ports:
//   b : in  7-bit message
//   c : out 12-bit codeword
module encoder (
    input  logic [6:0]  b,
    output logic [11:0] c
);

    logic p9;

    assign p9 = b[0] ^ b[1] ^ b[3] ^ b[5] ^ b[6];

    assign c[6:0] = b;
    assign c[7]   = b[0] ^ b[1] ^ b[5] ^ b[6];
    assign c[8]   = b[0] ^ b[2] ^ b[4] ^ b[5];
    assign c[9]   = p9;
    assign c[10]  = p9;
    assign c[11]  = b[1] ^ b[3] ^ b[5] ^ b[6];

endmodule

// File: rtl/encoder_scheduler.sv
// encoder_scheduler
// Shares one (12,7) encoder between NUM_REQ message requesters. A
// round-robin arbiter accepts one 7-bit message, the encoded codeword is
// latched, then streamed LSB-first on a 1-bit serial port with stall
// backpressure.
// Optional build macro: ENCODER_SCHED_B2B_EN -- lets the arbiter accept the
// next message in the cycle bit 11 is accepted (13-cycle period instead of 14).
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   req_valid  : in  per-requester message valid
//   req_data   : in  message i at bits [7i+6:7i]
//   req_ready  : out one-hot accept strobe (combinational)
//   ser_stall  : in  line driver cannot take the current bit
//   ser_out    : out current codeword bit
//   ser_valid  : out ser_out is valid
//   ser_sof    : out marks bit 0 of a codeword
//   ser_src    : out requester index of the codeword in flight
//   busy       : out FSM not idle
module encoder_scheduler
    import encoder_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int SRC_W   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [MSG_W*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       ser_stall,
    output logic                       ser_out,
    output logic                       ser_valid,
    output logic                       ser_sof,
    output logic [SRC_W-1:0]           ser_src,
    output logic                       busy
);

    state_t               state_q, state_d;
    logic [SRC_W-1:0]     last_grant_q, last_grant_d;
    logic [MSG_W-1:0]     msg_q, msg_d;
    logic [CW_W-1:0]      cw_q, cw_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ser_out_q, ser_out_d;
    logic                 ser_valid_q, ser_valid_d;
    logic                 ser_sof_q, ser_sof_d;
    logic [SRC_W-1:0]     src_q, src_d;
    logic                 busy_q, busy_d;

    logic [CW_W-1:0]      enc_c;
    logic [NUM_REQ-1:0]   grant;
    logic [SRC_W-1:0]     grant_idx;
    logic                 grant_any;
    logic                 last_bit_acc;
    logic                 arb_en;
    logic                 take;
    logic [CNT_W-1:0]     cnt_nxt;

    encoder u_enc (
        .b (msg_q),
        .c (enc_c)
    );

    // Round-robin search starting one past the last granted requester.
    always_comb begin : arb
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_REQ;
            if (!grant_any && req_valid[idx]) begin
                grant_any   = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = SRC_W'(idx);
            end
        end
    end

    assign last_bit_acc = (state_q == SHIFT) && (cnt_q == CNT_W'(CW_LAST)) && !ser_stall;

`ifdef ENCODER_SCHED_B2B_EN
    // The arbiter also runs in the slot where the final bit is taken.
    assign arb_en = (state_q == IDLE) || last_bit_acc;
`else
    assign arb_en = (state_q == IDLE);
`endif

    // rst_n gates the strobe so it reads 0 while reset is held.
    assign req_ready = (rst_n && arb_en) ? grant : '0;
    assign take      = rst_n && arb_en && grant_any;
    assign cnt_nxt   = cnt_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        msg_d        = msg_q;
        cw_d         = cw_q;
        cnt_d        = cnt_q;
        ser_out_d    = ser_out_q;
        ser_valid_d  = ser_valid_q;
        ser_sof_d    = ser_sof_q;
        src_d        = src_q;

        case (state_q)
            LOAD: begin
                // Bit 0 is presented straight from the encoder output so it
                // appears on the port in the first SHIFT cycle.
                cw_d        = enc_c;
                cnt_d       = '0;
                ser_out_d   = enc_c[0];
                ser_valid_d = 1'b1;
                ser_sof_d   = 1'b1;
                state_d     = SHIFT;
            end
            SHIFT: begin
                if (!ser_stall) begin
                    if (cnt_q == CNT_W'(CW_LAST)) begin
                        ser_out_d   = 1'b0;
                        ser_valid_d = 1'b0;
                        ser_sof_d   = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        cnt_d     = cnt_nxt;
                        ser_out_d = cw_q[cnt_nxt];
                        ser_sof_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Accept overrides the SHIFT->IDLE exit in the back-to-back slot.
        if (take) begin
            msg_d        = req_data[int'(grant_idx)*MSG_W +: MSG_W];
            src_d        = grant_idx;
            last_grant_d = grant_idx;
            state_d      = LOAD;
        end
    end

    assign busy_d = (state_d != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= SRC_W'(NUM_REQ - 1);
            msg_q        <= '0;
            cw_q         <= '0;
            cnt_q        <= '0;
            ser_out_q    <= 1'b0;
            ser_valid_q  <= 1'b0;
            ser_sof_q    <= 1'b0;
            src_q        <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            msg_q        <= msg_d;
            cw_q         <= cw_d;
            cnt_q        <= cnt_d;
            ser_out_q    <= ser_out_d;
            ser_valid_q  <= ser_valid_d;
            ser_sof_q    <= ser_sof_d;
            src_q        <= src_d;
            busy_q       <= busy_d;
        end
    end

    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign ser_sof   = ser_sof_q;
    assign ser_src   = src_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_encoder_scheduler.sv
module tb_encoder_scheduler;

    localparam int NUM_REQ = 2;
    localparam int SRC_W   = 2;
`ifdef ENCODER_SCHED_B2B_EN
    localparam int PERIOD = 13;
`else
    localparam int PERIOD = 14;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        req_valid = '0;
    logic [13:0]       req_data = '0;
    logic [1:0]        req_ready;
    logic              ser_stall = 1'b0;
    logic              ser_out;
    logic              ser_valid;
    logic              ser_sof;
    logic [SRC_W-1:0]  ser_src;
    logic              busy;

    encoder_scheduler #(.NUM_REQ(NUM_REQ), .SRC_W(SRC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .ser_stall (ser_stall),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_sof   (ser_sof),
        .ser_src   (ser_src),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Pending messages per requester, and the log of accepted handshakes.
    logic [6:0]  pend0[$];
    logic [6:0]  pend1[$];
    int          hs_src[$];
    int          hs_cyc[$];
    logic [6:0]  hs_data[$];
    logic [1:0]  hs_vld[$];
    int          hs_bad = 0;
    int          rdy_hi = 0;

    // Reassembled serial frames.
    logic [11:0] fr_cw[$];
    int          fr_src[$];
    int          fr_sof[$];
    int          fr_end[$];
    int          sof_err = 0;

    function automatic logic [11:0] enc_ref(input logic [6:0] m);
        logic [11:0] c;
        int pa, pb, pc, pd;
        pa = m[0] + m[1] + m[5] + m[6];
        pb = m[0] + m[2] + m[4] + m[5];
        pc = m[0] + m[1] + m[3] + m[5] + m[6];
        pd = m[1] + m[3] + m[5] + m[6];
        c = {5'b0, m};
        c[7]  = (pa % 2) == 1;
        c[8]  = (pb % 2) == 1;
        c[9]  = (pc % 2) == 1;
        c[10] = (pc % 2) == 1;
        c[11] = (pd % 2) == 1;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Requester driver: holds valid/data until the handshake, then moves on.
    initial begin
        logic [1:0] hs;
        forever begin
            @(negedge clk);
            hs = req_valid & req_ready;
            if (|req_ready) rdy_hi++;
            if (|hs) begin
                if (!$onehot(hs)) hs_bad++;
                hs_src.push_back(hs[1] ? 1 : 0);
                hs_cyc.push_back(cyc);
                hs_data.push_back(hs[1] ? req_data[13:7] : req_data[6:0]);
                hs_vld.push_back(req_valid);
            end
            @(posedge clk);
            #1;
            if (hs[0]) void'(pend0.pop_front());
            if (hs[1]) void'(pend1.pop_front());
            req_valid[0]    = (pend0.size() > 0);
            req_data[6:0]   = (pend0.size() > 0) ? pend0[0] : 7'h0;
            req_valid[1]    = (pend1.size() > 0);
            req_data[13:7]  = (pend1.size() > 0) ? pend1[0] : 7'h0;
        end
    end

    // Serial monitor: rebuilds codewords from accepted bits.
    initial begin
        logic [11:0] acc;
        int nb, sc;
        acc = '0; nb = 0; sc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                nb = 0;
            end else if (ser_valid && !ser_stall) begin
                if (ser_sof !== (nb == 0)) sof_err++;
                if (nb == 0) sc = cyc;
                acc[nb] = ser_out;
                nb++;
                if (nb == 12) begin
                    fr_cw.push_back(acc);
                    fr_src.push_back(int'(ser_src));
                    fr_sof.push_back(sc);
                    fr_end.push_back(cyc);
                    nb = 0;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic wait_frames(input int n);
        int b = 0;
        while (fr_cw.size() < n && b < 3000) begin
            @(negedge clk); #2; b++;
        end
        chk("frame_timeout", fr_cw.size() >= n, 1);
    endtask

    task automatic wait_hs(input int n);
        int b = 0;
        while (hs_cyc.size() < n && b < 3000) begin
            @(negedge clk); #2; b++;
        end
        chk("hs_timeout", hs_cyc.size() >= n, 1);
    endtask

    task automatic goto_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int nf, nh, t, vcnt, r0, ptr, ex;
        logic o;
        logic [6:0] d;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ser_out", ser_out, 0);
        chk("rst_ser_valid", ser_valid, 0);
        chk("rst_ser_sof", ser_sof, 0);
        chk("rst_ser_src", ser_src, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        rst_n = 1'b1;

        // Two simultaneous requesters: 0 wins first after reset
        pend0.push_back(7'h7F);
        pend1.push_back(7'h40);
        wait_frames(2);
        chk("rr_first_src", hs_src[0], 0);
        chk("rr_second_src", hs_src[1], 1);
        chk("rr_cw0", fr_cw[0], 12'h67F);
        chk("rr_cw1", fr_cw[1], 12'hEC0);
        chk("rr_ser_src0", fr_src[0], 0);
        chk("rr_ser_src1", fr_src[1], 1);
        chk("rr_accept_gap", hs_cyc[1] - hs_cyc[0], PERIOD);
        pend0.push_back(7'h7F);
        pend1.push_back(7'h40);
        wait_frames(4);
        chk("rr_again_src2", hs_src[2], 0);
        chk("rr_again_src3", hs_src[3], 1);
        repeat (4) @(negedge clk);
        #2;

        // Single request, data 0x01
        nf = fr_cw.size(); nh = hs_cyc.size(); r0 = rdy_hi;
        pend0.push_back(7'h01);
        wait_frames(nf + 1);
        t = hs_cyc[nh];
        chk("single_cw", fr_cw[nf], 12'h781);
        chk("single_sof_cyc", fr_sof[nf], t + 2);
        chk("single_end_cyc", fr_end[nf], t + 13);
        chk("single_src", fr_src[nf], 0);
        chk("single_hs_count", hs_cyc.size(), nh + 1);
        chk("single_ready_pulse", rdy_hi - r0, 1);
        repeat (4) @(negedge clk);
        #2;

        // Data 0x00: busy window and valid count
        nf = fr_cw.size(); nh = hs_cyc.size();
        pend1.push_back(7'h00);
        wait_hs(nh + 1);
        t = hs_cyc[nh];
        chk("zero_busy_T", busy, 0);
        vcnt = 0;
        for (int j = 1; j <= 13; j++) begin
            @(negedge clk); #2;
            chk("zero_busy_win", busy, 1);
            if (ser_valid) vcnt++;
            if (j == 1) chk("zero_valid_load", ser_valid, 0);
        end
        @(negedge clk); #2;
        chk("zero_busy_after", busy, 0);
        chk("zero_valid_after", ser_valid, 0);
        chk("zero_valid_cycles", vcnt, 12);
        chk("zero_cw", fr_cw[nf], 12'h000);
        chk("zero_src", fr_src[nf], 1);
        repeat (3) @(negedge clk);
        #2;

        // Stall 3 cycles at bit 5 of 0x781
        nf = fr_cw.size(); nh = hs_cyc.size();
        pend0.push_back(7'h01);
        wait_hs(nh + 1);
        t = hs_cyc[nh];
        goto_cyc(t + 7);
        ser_stall = 1'b1;
        o = ser_out;
        chk("stall_bit5", o, 0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk); #2;
            chk("stall_hold_out", ser_out, o);
            chk("stall_hold_valid", ser_valid, 1);
            chk("stall_hold_sof", ser_sof, 0);
        end
        goto_cyc(t + 10);
        ser_stall = 1'b0;
        wait_frames(nf + 1);
        chk("stall_cw", fr_cw[nf], 12'h781);
        chk("stall_end_cyc", fr_end[nf], t + 16);
        repeat (4) @(negedge clk);
        #2;

        // Reset at bit 6 with requester 1 pending
        nf = fr_cw.size(); nh = hs_cyc.size();
        pend0.push_back(7'h01);
        wait_hs(nh + 1);
        t = hs_cyc[nh];
        goto_cyc(t + 8);
        pend1.push_back(7'h55);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_ser_out", ser_out, 0);
        chk("arst_ser_valid", ser_valid, 0);
        chk("arst_ser_sof", ser_sof, 0);
        chk("arst_ser_src", ser_src, 0);
        chk("arst_busy", busy, 0);
        chk("arst_req_ready", req_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_frames(nf + 1);
        chk("arst_next_src", hs_src[nh + 1], 1);
        chk("arst_frame_cw", fr_cw[nf], enc_ref(7'h55));
        chk("arst_frame_src", fr_src[nf], 1);
        chk("arst_frame_len", fr_end[nf] - fr_sof[nf], 11);
        repeat (4) @(negedge clk);
        #2;
        chk("arst_no_remnant", fr_cw.size(), nf + 1);

        // Continuous valid on requester 0: SOF spacing
        nf = fr_cw.size(); nh = hs_cyc.size();
        for (int j = 0; j < 3; j++) begin
            d = 7'($urandom);
            pend0.push_back(d);
        end
        wait_frames(nf + 3);
        chk("period_01", fr_sof[nf + 1] - fr_sof[nf], PERIOD);
        chk("period_12", fr_sof[nf + 2] - fr_sof[nf + 1], PERIOD);
        for (int j = 0; j < 3; j++)
            chk("period_cw", fr_cw[nf + j], enc_ref(hs_data[nh + j]));
        repeat (4) @(negedge clk);
        #2;

        // Random traffic and stalls against the round-robin/encoder model
        nf = fr_cw.size(); nh = hs_cyc.size();
        ptr = hs_src[nh - 1];
        for (int j = 0; j < 600; j++) begin
            @(posedge clk); #1;
            ser_stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0 && pend0.size() < 2) pend0.push_back(7'($urandom));
            if ($urandom_range(0, 9) == 0 && pend1.size() < 2) pend1.push_back(7'($urandom));
        end
        ser_stall = 1'b0;
        begin
            int b = 0;
            while ((pend0.size() > 0 || pend1.size() > 0 || busy) && b < 3000) begin
                @(negedge clk); #2; b++;
            end
            chk("rand_drain", b < 3000, 1);
        end
        chk("rand_frames", fr_cw.size() - nf, hs_cyc.size() - nh);
        for (int k = nh; k < hs_cyc.size(); k++) begin
            ex = (ptr + 1) % NUM_REQ;
            if (!hs_vld[k][ex]) ex = (ex + 1) % NUM_REQ;
            chk("rand_rr_src", hs_src[k], ex);
            ptr = ex;
            if (nf + k - nh < fr_cw.size()) begin
                chk("rand_cw", fr_cw[nf + k - nh], enc_ref(hs_data[k]));
                chk("rand_src", fr_src[nf + k - nh], hs_src[k]);
            end
        end

        chk("sof_only_bit0", sof_err, 0);
        chk("ready_onehot", hs_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/encoder_scheduler.md
# encoder_scheduler

Shares one combinational (12,7) `encoder` instance between NUM_REQ message requesters. Arbitrates round-robin, registers the granted 7-bit message, and latches the 12-bit codeword. It then streams the codeword LSB-first on a 1-bit serial port with stall backpressure. It sits between the message sources and the serial line driver.

## Interface
- NUM_REQ, default 2: number of requesters, legal 2..4.
- SRC_W, default 2: width of source ID, ≥ clog2(NUM_REQ).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester message valid.
- req_data  in  7*NUM_REQ  message i at bits [7i+6:7i].
- req_ready  out  NUM_REQ  one-hot grant/accept strobe.
- ser_stall  in  1  line driver cannot take the current bit.
- ser_out  out  1  current codeword bit.
- ser_valid  out  1  ser_out is valid.
- ser_sof  out  1  marks bit 0 of a codeword.
- ser_src  out  SRC_W  requester index of the codeword in flight.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, LOAD, SHIFT.
- IDLE:
  - If any req_valid, grant the first valid requester, searching from last_grant+1 (wrapping).
  - req_ready[g] is combinational: state==IDLE && grant[g]. Handshake completes on req_valid&&req_ready.
  - Capture req_data[g] into msg_reg and g into ser_src. Update last_grant to g. Go to LOAD.
- LOAD:
  - Latch encoder(msg_reg) into cw_reg[11:0]. Clear bit counter to 0. Go to SHIFT.
  - ser_stall is ignored in LOAD.
- SHIFT:
  - ser_valid=1, ser_out=cw_reg[cnt], ser_sof=(cnt==0).
  - A bit is accepted when ser_valid && !ser_stall; cnt then increments.
  - While stalled, all serial outputs and cnt hold.
  - Acceptance of bit 11 → IDLE, unless back-to-back applies (see Configuration).
- Codeword mapping:
  - c[6:0]=b
  - c7=b0^b1^b5^b6
  - c8=b0^b2^b4^b5
  - c9=c10=b0^b1^b3^b5^b6
  - c11=b1^b3^b5^b6
- Requester rules:
  - Requesters must hold valid and data stable until accepted.
  - req_valid must not depend on req_ready.
- Arbitration:
  - Simultaneous requests: the round-robin pointer decides.
  - A requester that drops valid before grant is simply skipped.
- Reset values: state IDLE, ser_out 0, ser_valid 0, ser_sof 0, ser_src 0, busy 0, req_ready 0, cnt 0, msg_reg 0, cw_reg 0.
- last_grant resets to NUM_REQ-1, so requester 0 wins first.
- Reset mid-codeword: the frame is abandoned immediately and never resumed. Outputs go to reset values asynchronously.

## Timing
- All outputs are registered except req_ready.
- Accept at cycle T, LOAD at T+1, bit 0 with ser_sof at T+2, bit 11 at T+13 with no stalls.
- Each stall cycle adds one cycle.
- Period without the macro: 14 cycles per codeword (accept + LOAD + 12 bits).
- req_ready is never asserted outside IDLE, or outside the back-to-back slot.

## Configuration
- ENCODER_SCHED_B2B_EN defined: back-to-back operation.
  - In SHIFT, while bit 11 is being accepted, the arbiter runs and may assert req_ready.
  - On handshake, go directly to LOAD. Period becomes 13 cycles.
  - If bit 11 is stalled, no grant is made that cycle.
- ENCODER_SCHED_B2B_EN undefined:
  - Grants occur only in IDLE.
  - A one-cycle IDLE gap always follows bit 11.

## Structure
- Package encoder_sched_pkg holds:
  - MSG_W=7, CW_W=12, CNT_W=4.
  - State enum state_t {IDLE, LOAD, SHIFT}.
  - CW_LAST=11.
- Instantiate the existing combinational `encoder` (b[6:0] → c[11:0]) as the single sub-module.
- Round-robin arbiter logic stays inline; it is too small to split out.

## Test plan
- Single request, req_valid[0]=1, data 7'h01:
  - req_ready[0] pulses 1 cycle.
  - Serial bits LSB-first = 12'h781, bits at T+2..T+13, ser_sof only at T+2, ser_src=0.
- Requesters 0 and 1 valid together, data 7'h7F and 7'h40:
  - Requester 0 served first (12'h67F), then requester 1 (12'hEC0).
  - Then re-request both: requester 0 is granted again only after 1 (round-robin holds).
- Data 7'h00:
  - All 12 bits 0, ser_valid high for 12 cycles.
  - busy high from T+1 through T+13.
- ser_stall high for 3 cycles at bit 5 of 12'h781:
  - ser_out and cnt hold; last bit at T+16.
  - No duplicated or dropped bits.
- rst_n low at bit 6:
  - All outputs at reset values immediately.
  - After release, a pending valid[1] is granted.
  - First frame shows ser_sof, with no remnant of the aborted codeword.
- With ENCODER_SCHED_B2B_EN and continuous valid on requester 0:
  - Successive ser_sof pulses are 13 cycles apart.
  - Without the macro they are 14 cycles apart.
